router_pkt_reader: RTL and testbench

- Drain-side consumer of one router output FIFO.
- Issues read_enb while the FIFO is non-empty and it has buffer space, then parses the byte stream into packets. Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte.
- Forwards every byte to a valid/ready sink with sop/eop framing.
- Checks XOR parity and counts packets. Sits between router_fifo and the destination client.

---
 rtl/router_pkt_reader.sv | 177 +++++++++++++++++
 tb/tb_router_pkt_reader.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_reader.sv
// Drain-side reader for one router output FIFO: fetches bytes into a 2-entry skid buffer,
// frames them as {header, payload, parity} packets and checks XOR parity.
module router_pkt_reader #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_data,
    output logic             fifo_read_enb,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic [1:0]       pkt_addr,
    output logic [5:0]       pkt_len,
    output logic             parity_err,
    output logic             pkt_done,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {StHdr, StPay, StPar} state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    buf_data_q [2];
    logic [DW-1:0]    buf_data_d [2];
    logic             buf_sop_q [2];
    logic             buf_sop_d [2];
    logic             buf_eop_q [2];
    logic             buf_eop_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             inflight_q, inflight_d;
    logic [5:0]       rem_q, rem_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [1:0]       pkt_addr_q, pkt_addr_d;
    logic [5:0]       pkt_len_q, pkt_len_d;
    logic             parity_err_q, parity_err_d;
    logic             pkt_done_q, pkt_done_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
    logic             pop;
    logic [2:0]       occ_sum;

    assign out_valid  = (count_q != 2'd0);
    assign out_data   = buf_data_q[rd_ptr_q];
    assign out_sop    = buf_sop_q[rd_ptr_q];
    assign out_eop    = buf_eop_q[rd_ptr_q];
    assign pkt_addr   = pkt_addr_q;
    assign pkt_len    = pkt_len_q;
    assign parity_err = parity_err_q;
    assign pkt_done   = pkt_done_q;
    assign good_cnt   = good_cnt_q;
    assign bad_cnt    = bad_cnt_q;
    assign busy       = (state_q != StHdr);

    // Occupancy net of this cycle's pop keeps reads back-to-back at full rate while the
    // buffer still can never exceed two entries.
    always_comb begin
        pop           = out_valid && out_ready;
        occ_sum       = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        fifo_read_enb = !fifo_empty && (occ_sum < 3'd2);
    end

    always_comb begin
        state_d      = state_q;
        buf_data_d   = buf_data_q;
        buf_sop_d    = buf_sop_q;
        buf_eop_d    = buf_eop_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + 2'(inflight_q) - 2'(pop);
        inflight_d   = fifo_read_enb;
        rem_d        = rem_q;
        acc_d        = acc_q;
        pkt_addr_d   = pkt_addr_q;
        pkt_len_d    = pkt_len_q;
        parity_err_d = 1'b0;
        pkt_done_d   = 1'b0;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;

        if (inflight_q) begin
            buf_data_d[wr_ptr_q] = fifo_data;
            buf_sop_d[wr_ptr_q]  = (state_q == StHdr);
            buf_eop_d[wr_ptr_q]  = (state_q == StPar);
            wr_ptr_d             = !wr_ptr_q;
            unique case (state_q)
                StHdr: begin
                    pkt_len_d  = fifo_data[7:2];
                    pkt_addr_d = fifo_data[1:0];
                    rem_d      = fifo_data[7:2];
                    acc_d      = fifo_data;
                    state_d    = (fifo_data[7:2] != 6'd0) ? StPay : StPar;
                end
                StPay: begin
                    acc_d = acc_q ^ fifo_data;
                    rem_d = rem_q - 6'd1;
                    if (rem_q == 6'd1) state_d = StPar;
                end
                StPar: begin
                    pkt_done_d   = 1'b1;
                    parity_err_d = (fifo_data != acc_q);
                    if (fifo_data != acc_q) bad_cnt_d = bad_cnt_q + 1'b1;
                    else                    good_cnt_d = good_cnt_q + 1'b1;
                    state_d = StHdr;
                end
                default: state_d = StHdr;
            endcase
        end
        if (pop) rd_ptr_d = !rd_ptr_q;

        if (soft_reset) begin
            state_d      = StHdr;
            buf_data_d   = '{default: '0};
            buf_sop_d    = '{default: 1'b0};
            buf_eop_d    = '{default: 1'b0};
            wr_ptr_d     = 1'b0;
            rd_ptr_d     = 1'b0;
            count_d      = 2'd0;
            inflight_d   = 1'b0;
            rem_d        = 6'd0;
            acc_d        = '0;
            pkt_addr_d   = 2'd0;
            pkt_len_d    = 6'd0;
            parity_err_d = 1'b0;
            pkt_done_d   = 1'b0;
            good_cnt_d   = '0;
            bad_cnt_d    = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StHdr;
            buf_data_q   <= '{default: '0};
            buf_sop_q    <= '{default: 1'b0};
            buf_eop_q    <= '{default: 1'b0};
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            inflight_q   <= 1'b0;
            rem_q        <= 6'd0;
            acc_q        <= '0;
            pkt_addr_q   <= 2'd0;
            pkt_len_q    <= 6'd0;
            parity_err_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            buf_data_q   <= buf_data_d;
            buf_sop_q    <= buf_sop_d;
            buf_eop_q    <= buf_eop_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            rem_q        <= rem_d;
            acc_q        <= acc_d;
            pkt_addr_q   <= pkt_addr_d;
            pkt_len_q    <= pkt_len_d;
            parity_err_q <= parity_err_d;
            pkt_done_q   <= pkt_done_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

endmodule

// File: tb/tb_router_pkt_reader.sv
// Directed bench for router_pkt_reader: a queue models the router FIFO, a negedge monitor
// records every accepted output byte and status pulse.
module tb_router_pkt_reader;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       soft_reset = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_read_enb;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic [1:0] pkt_addr;
    logic [5:0] pkt_len;
    logic       parity_err;
    logic       pkt_done;
    logic [7:0] good_cnt;
    logic [7:0] bad_cnt;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] fq [$];
    logic [9:0] exp_q [$];
    logic [9:0] got_q [$];
    int         run_q [$];
    logic       stall = 1'b0;
    logic       toggle_en = 1'b0;
    logic       phase = 1'b0;
    int         done_n = 0;
    int         perr_n = 0;
    int         both_n = 0;
    int         gap_n = 0;
    int         cyc = 0;
    int         prev_acc = -10;
    int         run = 0;

    router_pkt_reader #(.DW(8), .CNT_W(8)) dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_enb(fifo_read_enb),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .pkt_addr(pkt_addr), .pkt_len(pkt_len),
        .parity_err(parity_err), .pkt_done(pkt_done), .good_cnt(good_cnt),
        .bad_cnt(bad_cnt), .busy(busy)
    );

    always #5 clock = ~clock;

    // FIFO model: data appears the cycle after a read strobe
    always @(posedge clock) begin
        if (fifo_read_enb && fq.size() > 0) fifo_data <= fq.pop_front();
    end

    always begin
        @(posedge clock);
        #1;
        fifo_empty = (fq.size() == 0) || stall || (toggle_en && phase);
        phase = ~phase;
    end

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (resetn && out_valid && out_ready) begin
            got_q.push_back({out_sop, out_eop, out_data});
            if (cyc != prev_acc + 1) gap_n <= gap_n + 1;
            prev_acc <= cyc;
        end
        if (pkt_done) done_n <= done_n + 1;
        if (parity_err) perr_n <= perr_n + 1;
        if (pkt_done && parity_err) both_n <= both_n + 1;
        if (fifo_read_enb) run <= run + 1;
        else begin
            if (run > 0) run_q.push_back(run);
            run <= 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic hard_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] seed,
                            input bit corrupt);
        logic [7:0] acc;
        logic [7:0] b;
        acc = hdr;
        fq.push_back(hdr);
        exp_q.push_back({2'b10, hdr});
        for (int i = 0; i < n; i++) begin
            b = seed + 8'(i * 37);
            acc = acc ^ b;
            fq.push_back(b);
            exp_q.push_back({2'b00, b});
        end
        if (corrupt) acc = ~acc;
        fq.push_back(acc);
        exp_q.push_back({2'b01, acc});
    endtask

    task automatic wait_got(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        repeat (4) tick();
    endtask

    function automatic int stream_errs(input int gb, input int eb, input int n);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (gb + i >= got_q.size() || eb + i >= exp_q.size()) e++;
            else if (got_q[gb + i] !== exp_q[eb + i]) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        hard_reset();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_read_enb !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got valid=%b busy=%b rd=%b want 0 0 0",
                     out_valid, busy, fifo_read_enb);
        end
        checks++;
        if (good_cnt !== 8'd0 || bad_cnt !== 8'd0 || pkt_len !== 6'd0 || pkt_addr !== 2'd0) begin
            failures++;
            $display("FAIL reset_status: got good=%0d bad=%0d len=%0d addr=%0d want all 0",
                     good_cnt, bad_cnt, pkt_len, pkt_addr);
        end
    endtask

    task automatic test_good_packet();
        int gb = got_q.size();
        int eb = exp_q.size();
        int rb = run_q.size();
        int d0 = done_n;
        int p0 = perr_n;
        int r;
        int e;
        out_ready = 1'b1;
        send_pkt(8'h39, 14, 8'h5A, 1'b0);
        wait_got(gb + 16, 400);
        e = stream_errs(gb, eb, 16);
        checks++;
        if (got_q.size() !== gb + 16 || e !== 0) begin
            failures++;
            $display("FAIL good_stream: got n=%0d errs=%0d want n=16 errs=0", got_q.size() - gb, e);
        end
        checks++;
        if (pkt_addr !== 2'b01 || pkt_len !== 6'd14) begin
            failures++;
            $display("FAIL good_fields: got addr=%0d len=%0d want 1 14", pkt_addr, pkt_len);
        end
        checks++;
        if (done_n - d0 !== 1 || perr_n - p0 !== 0 || good_cnt !== 8'd1) begin
            failures++;
            $display("FAIL good_status: got done=%0d perr=%0d good=%0d want 1 0 1",
                     done_n - d0, perr_n - p0, good_cnt);
        end
        r = (run_q.size() > rb) ? run_q[rb] : -1;
        checks++;
        if (r !== 16) begin
            failures++;
            $display("FAIL good_read_run: got %0d want 16", r);
        end
    endtask

    task automatic test_bad_parity();
        int gb;
        int eb;
        int d0;
        int p0;
        int b0;
        int e;
        hard_reset();
        gb = got_q.size();
        eb = exp_q.size();
        d0 = done_n;
        p0 = perr_n;
        b0 = both_n;
        send_pkt(8'h39, 14, 8'h5A, 1'b1);
        wait_got(gb + 16, 400);
        e = stream_errs(gb, eb, 16);
        checks++;
        if (got_q.size() !== gb + 16 || e !== 0) begin
            failures++;
            $display("FAIL bad_stream: got n=%0d errs=%0d want n=16 errs=0", got_q.size() - gb, e);
        end
        checks++;
        if (done_n - d0 !== 1 || perr_n - p0 !== 1 || both_n - b0 !== 1) begin
            failures++;
            $display("FAIL bad_pulses: got done=%0d perr=%0d both=%0d want 1 1 1",
                     done_n - d0, perr_n - p0, both_n - b0);
        end
        checks++;
        if (good_cnt !== 8'd0 || bad_cnt !== 8'd1) begin
            failures++;
            $display("FAIL bad_counts: got good=%0d bad=%0d want 0 1", good_cnt, bad_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int gb = got_q.size();
        int eb = exp_q.size();
        int g0 = gap_n;
        int d0 = done_n;
        int e;
        send_pkt(8'h39, 14, 8'h13, 1'b0);
        send_pkt(8'h02, 0, 8'h00, 1'b0);
        wait_got(gb + 18, 400);
        e = stream_errs(gb, eb, 18);
        checks++;
        if (got_q.size() !== gb + 18 || e !== 0) begin
            failures++;
            $display("FAIL b2b_stream: got n=%0d errs=%0d want n=18 errs=0", got_q.size() - gb, e);
        end
        checks++;
        if (gap_n - g0 !== 1) begin
            failures++;
            $display("FAIL b2b_idle: got bursts=%0d want 1", gap_n - g0);
        end
        checks++;
        if (good_cnt !== 8'd2 || done_n - d0 !== 2 || pkt_addr !== 2'b10 || pkt_len !== 6'd0) begin
            failures++;
            $display("FAIL b2b_status: got good=%0d done=%0d addr=%0d len=%0d want 2 2 2 0",
                     good_cnt, done_n - d0, pkt_addr, pkt_len);
        end
    endtask

    task automatic test_backpressure();
        int gb = got_q.size();
        int eb = exp_q.size();
        int unstable = 0;
        int reads = 0;
        int held_n;
        int e;
        logic [7:0] held;
        send_pkt(8'h39, 14, 8'hC4, 1'b0);
        while (got_q.size() < gb + 4) tick();
        out_ready = 1'b0;
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== held) unstable++;
            if (i >= 2 && fifo_read_enb !== 1'b0) reads++;
        end
        held_n = got_q.size() - gb;
        checks++;
        if (unstable !== 0 || held_n !== 4) begin
            failures++;
            $display("FAIL bp_hold: got unstable=%0d accepted=%0d want 0 4", unstable, held_n);
        end
        checks++;
        if (reads !== 0) begin
            failures++;
            $display("FAIL bp_read_gate: got reads=%0d want 0", reads);
        end
        out_ready = 1'b1;
        wait_got(gb + 16, 400);
        e = stream_errs(gb, eb, 16);
        checks++;
        if (got_q.size() !== gb + 16 || e !== 0 || good_cnt !== 8'd3) begin
            failures++;
            $display("FAIL bp_stream: got n=%0d errs=%0d good=%0d want 16 0 3",
                     got_q.size() - gb, e, good_cnt);
        end
    endtask

    task automatic test_empty_toggle();
        int gb = got_q.size();
        int eb = exp_q.size();
        int e;
        toggle_en = 1'b1;
        send_pkt(8'hFF, 63, 8'h29, 1'b0);
        wait_got(gb + 65, 1000);
        toggle_en = 1'b0;
        e = stream_errs(gb, eb, 65);
        checks++;
        if (got_q.size() !== gb + 65 || e !== 0) begin
            failures++;
            $display("FAIL toggle_stream: got n=%0d errs=%0d want n=65 errs=0",
                     got_q.size() - gb, e);
        end
        checks++;
        if (pkt_len !== 6'd63 || pkt_addr !== 2'b11 || good_cnt !== 8'd4) begin
            failures++;
            $display("FAIL toggle_status: got len=%0d addr=%0d good=%0d want 63 3 4",
                     pkt_len, pkt_addr, good_cnt);
        end
    endtask

    task automatic test_soft_reset();
        int gb = got_q.size();
        int eb;
        int e;
        send_pkt(8'h39, 14, 8'h88, 1'b0);
        while (got_q.size() < gb + 5) tick();
        stall = 1'b1;
        tick();
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || good_cnt !== 8'd0 || bad_cnt !== 8'd0 ||
            pkt_len !== 6'd0) begin
            failures++;
            $display("FAIL soft_clear: got valid=%b busy=%b good=%0d bad=%0d len=%0d want 0",
                     out_valid, busy, good_cnt, bad_cnt, pkt_len);
        end
        fq.delete();
        tick();
        gb = got_q.size();
        eb = exp_q.size();
        stall = 1'b0;
        send_pkt(8'h39, 14, 8'h77, 1'b0);
        wait_got(gb + 16, 400);
        e = stream_errs(gb, eb, 16);
        checks++;
        if (got_q.size() !== gb + 16 || e !== 0 || good_cnt !== 8'd1 || bad_cnt !== 8'd0) begin
            failures++;
            $display("FAIL soft_after: got n=%0d errs=%0d good=%0d bad=%0d want 16 0 1 0",
                     got_q.size() - gb, e, good_cnt, bad_cnt);
        end
    endtask

    task automatic test_wrap();
        int gb = got_q.size();
        int d0 = done_n;
        for (int i = 0; i < 255; i++) send_pkt(8'h01, 0, 8'h00, 1'b0);
        wait_got(gb + 510, 2000);
        checks++;
        if (good_cnt !== 8'd0 || done_n - d0 !== 255) begin
            failures++;
            $display("FAIL cnt_wrap: got good=%0d done=%0d want 0 255", good_cnt, done_n - d0);
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_back_to_back();
        test_backpressure();
        test_empty_toggle();
        test_soft_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
